// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter for IF fetches and MEM loads/stores; registered RAM outputs, 1-cycle done pulse.
// Optional ARB_ROUND_ROBIN_EN: alternate grants under contention instead of fixed MEM priority.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic [1:0]        mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_size,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cyc_q, cyc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              is_if_q, is_if_d;
  logic              is_store_q, is_store_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic [1:0]        owner_q, owner_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic              last_mem_q, last_mem_d;
`endif

  logic       if_ok, mem_ok, grant_mem, finish;
  logic [2:0] n_bytes;
  logic [1:0] byte_sel;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    is_if_d     = is_if_q;
    is_store_d  = is_store_q;
    buf_d       = buf_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = ram_wr_q;
    owner_d     = owner_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_mem_d  = last_mem_q;
`endif

    if_ok  = if_req && !if_flush;
    mem_ok = (mem_req != 2'b00);
`ifdef ARB_ROUND_ROBIN_EN
    grant_mem = mem_ok && (!if_ok || !last_mem_q);
`else
    grant_mem = mem_ok;
`endif

    if (is_if_q || size_q[1]) n_bytes = 3'd4;
    else if (size_q[0])       n_bytes = 3'd2;
    else                      n_bytes = 3'd1;

    // cyc_q counts cycles since grant; read byte k lands in cycle k+2.
    byte_sel = cyc_q[1:0] - 2'd2;
    finish   = is_store_q ? (cyc_q == n_bytes) : (cyc_q == 3'(n_bytes + 3'd1));

    case (state_q)
      IDLE: begin
        if (grant_mem || if_ok) begin
          is_if_d    = !grant_mem;
          is_store_d = grant_mem && (mem_req == 2'b10);
          addr_d     = grant_mem ? mem_addr : if_addr;
          size_d     = mem_size;
          wdata_d    = mem_wdata;
          buf_d      = 32'h0;
          cyc_d      = 3'd1;
          ram_a_d    = grant_mem ? mem_addr : if_addr;
          ram_wr_d   = grant_mem && (mem_req == 2'b10);
          ram_dout_d = grant_mem ? mem_wdata[7:0] : 8'h00;
          owner_d    = grant_mem ? 2'b10 : 2'b01;
          state_d    = XFER;
`ifdef ARB_ROUND_ROBIN_EN
          last_mem_d = grant_mem;
`endif
        end
      end
      XFER: begin
        if (is_if_q && if_flush) begin
          state_d  = IDLE;
          owner_d  = 2'b00;
          ram_wr_d = 1'b0;
          cyc_d    = 3'd0;
        end else begin
          cyc_d = cyc_q + 3'd1;
          if (cyc_q < n_bytes) begin
            ram_a_d    = addr_q + ADDR_W'(cyc_q);
            ram_wr_d   = is_store_q;
            ram_dout_d = wdata_q[{cyc_q[1:0], 3'b000} +: 8];
          end else begin
            ram_wr_d = 1'b0;
          end
          if (!is_store_q && cyc_q >= 3'd2)
            buf_d[{byte_sel, 3'b000} +: 8] = ram_din;
          if (finish) begin
            state_d  = DONE;
            owner_d  = 2'b00;
            ram_wr_d = 1'b0;
            cyc_d    = 3'd0;
            if (is_if_q) begin
              if_done_d = 1'b1;
              if_data_d = buf_d;
            end else begin
              mem_done_d = 1'b1;
              if (!is_store_q) mem_rdata_d = buf_d;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cyc_q       <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      size_q      <= 2'b00;
      is_if_q     <= 1'b0;
      is_store_q  <= 1'b0;
      buf_q       <= 32'h0;
      if_data_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      ram_a_q     <= '0;
      ram_dout_q  <= 8'h00;
      ram_wr_q    <= 1'b0;
      owner_q     <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
      last_mem_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      is_if_q     <= is_if_d;
      is_store_q  <= is_store_d;
      buf_q       <= buf_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      owner_q     <= owner_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_mem_q  <= last_mem_d;
`endif
    end
  end

  assign if_data   = if_data_q;
  assign if_done   = if_done_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_done  = mem_done_q;
  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q;
  assign owner     = owner_q;

endmodule
